ro_freq_counter: RTL

Multi-channel ring-oscillator frequency counter for the RO tile family. It samples up to NUM_RO asynchronous, pre-divided oscillator outputs and counts their rising edges over a programmable gate window of clk cycles. It holds the per-channel counts in result registers for readout by the tile's top-level I/O mux. It supports single-shot and continuous measurement and saturates on overflow.

---
 rtl/ro_freq_counter.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/ro_freq_counter.sv
// ro_freq_counter
//   Multi-channel ring-oscillator frequency counter. Each channel passes an
//   asynchronous, pre-divided oscillator through a 3-flop synchronizer. Its
//   rising edges are counted over a gate window of gate_len+1 clk cycles.
//   At the end of each window the counts are copied into result registers.
//   The result registers hold their values while the next window counts.
//   Supports single-shot and continuous measurement. Counters saturate at
//   all-ones and flag the saturation.
//
// Ports
//   clk         system clock; all logic is on the rising edge
//   rst         synchronous, active-high reset
//   ro_in       [NUM_RO]  asynchronous oscillator outputs
//   start       measurement request; only acted on in IDLE
//   continuous  re-arm after each window; sampled in LATCH
//   gate_len    [GATE_W]  window length minus one; sampled in ARM
//   rd_sel      [SEL_W]   result channel select
//   rd_data     [CNT_W]   result[rd_sel]; 0 for an out-of-range select
//   ovf         [NUM_RO]  saturation flags of the last completed window
//   busy        high while in ARM, COUNT or LATCH
//   done        one-cycle pulse when new results become visible
module ro_freq_counter #(
  parameter  int NUM_RO = 4,
  parameter  int CNT_W  = 16,
  parameter  int GATE_W = 12,
  localparam int SEL_W  = (NUM_RO > 1) ? $clog2(NUM_RO) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_RO-1:0] ro_in,
  input  logic              start,
  input  logic              continuous,
  input  logic [GATE_W-1:0] gate_len,
  input  logic [SEL_W-1:0]  rd_sel,
  output logic [CNT_W-1:0]  rd_data,
  output logic [NUM_RO-1:0] ovf,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARM   = 2'd1,
    ST_COUNT = 2'd2,
    ST_LATCH = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [GATE_W-1:0]   win_q, win_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  // Per-channel control strobes, all decoded from the current state.
  logic clr_cnt, en_cnt, ld_res;

  // Result registers of all channels, gathered for the read mux.
  logic [NUM_RO-1:0][CNT_W-1:0] res_bus;

  // ---------------------------------------------------------------------------
  // Control FSM and gate-window down-counter
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    done_d  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_ARM;
      end
      ST_ARM: begin
        win_d   = gate_len;
        state_d = ST_COUNT;
      end
      ST_COUNT: begin
        // The window ends on the cycle the down-counter reads zero, so
        // COUNT lasts gate_len+1 cycles.
        if (win_q == '0) begin
          state_d = ST_LATCH;
        end else begin
          win_d = win_q - 1'b1;
        end
      end
      ST_LATCH: begin
        done_d  = 1'b1;
        state_d = continuous ? ST_ARM : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    // busy is registered from the next state so that it tracks the state
    // register exactly.
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      win_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign clr_cnt = (state_q == ST_ARM);
  assign en_cnt  = (state_q == ST_COUNT);
  assign ld_res  = (state_q == ST_LATCH);

  // ---------------------------------------------------------------------------
  // Per-channel synchronizer, edge counter and result register
  // ---------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < NUM_RO; gi++) begin : g_ch
      // sync_q[0] and sync_q[1] are the synchronizer stages. sync_q[2] delays
      // stage 2 by one cycle so that a rising edge is seen for exactly one cycle.
      logic [2:0]       sync_q, sync_d;
      logic             rise;
      logic [CNT_W-1:0] cnt_q, cnt_d;
      logic             sat_q, sat_d;
      logic [CNT_W-1:0] res_q, res_d;
      logic             rovf_q, rovf_d;

      assign rise = sync_q[1] & ~sync_q[2];

      always_comb begin
        sync_d = {sync_q[1:0], ro_in[gi]};
        cnt_d  = cnt_q;
        sat_d  = sat_q;
        res_d  = res_q;
        rovf_d = rovf_q;
        if (clr_cnt) begin
          cnt_d = '0;
          sat_d = 1'b0;
        end else if (en_cnt && rise) begin
          // At all-ones the counter holds its value and latches the overflow.
          if (cnt_q == '1) begin
            sat_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        if (ld_res) begin
          res_d  = cnt_q;
          rovf_d = sat_q;
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          sync_q <= '0;
          cnt_q  <= '0;
          sat_q  <= 1'b0;
          res_q  <= '0;
          rovf_q <= 1'b0;
        end else begin
          sync_q <= sync_d;
          cnt_q  <= cnt_d;
          sat_q  <= sat_d;
          res_q  <= res_d;
          rovf_q <= rovf_d;
        end
      end

      assign res_bus[gi] = res_q;
      assign ovf[gi]     = rovf_q;
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Readout
  // ---------------------------------------------------------------------------
  always_comb begin
    rd_data = '0;
    if (int'(rd_sel) < NUM_RO) rd_data = res_bus[rd_sel];
  end

  assign busy = busy_q;
  assign done = done_q;

endmodule
